ai_paddle_tracker: RTL and testbench
====================================

// Module: ai_paddle_tracker
// PURPOSE
//  Parametrised computer-player paddle controller for pong. Consumes ball position
//  updates and drives the right-hand paddle position.
//  Adds to the legacy follow-the-ball AI: ball direction detection, a rate-limited
//  chase with dead-band, return-to-home when the ball recedes, and target clamping.
//  Sits between the ball engine and the paddle renderer; POSITION feeds the renderer.
// PARAMETERS
//  COORD_W   11   width of ball coordinates and internal paddle register
//  POS_W     8    width of POSITION output
//  POS_SHIFT 1    POSITION = paddle >> POS_SHIFT (2 px resolution at default)
//  FIELD_H   470  playfield height, px
//  PADDLE_H  60   paddle height, px
//  NET_X     391  ball H strictly above this is on the AI side
//  TICK_DIV  500000  CLOCK cycles per movement tick (>=1)
//  MAX_STEP  4    max px moved per tick in CHASE/HOME (MODE=1)
//  DEADBAND  2    no movement while |target-paddle| <= DEADBAND (MODE=1)
// PORTS
//  CLOCK       in   1        system clock, all logic on rising edge
//  RESET       in   1        asynchronous, active-low reset (0 = reset)
//  ENABLE      in   1        1 = AI plays; 0 = force IDLE
//  MODE        in   1        0 = snap (legacy follow), 1 = rate-limited
//  BALL_VALID  in   1        1-cycle strobe: BALL_H/BALL_V carry a new ball position
//  BALL_H      in   COORD_W  ball horizontal position, px
//  BALL_V      in   COORD_W  ball vertical position (centre), px
//  POSITION    out  POS_W    paddle top, px >> POS_SHIFT, truncated to POS_W
//  MOVING      out  1        1 while paddle changed on the most recent tick
//  STATE       out  2        0 IDLE, 1 HOME, 2 CHASE (3 unused)
// BEHAVIOUR
//  Reset (RESET=0, async): paddle = HOME_Y = (FIELD_H-PADDLE_H)/2; STATE=IDLE;
//   last_h=0; approaching=0; tick counter=0; MOVING=0. Release is sampled synchronously.
//  Tick: counter 0..TICK_DIV-1; tick=1 for the cycle the counter wraps to 0.
//   Counter runs in all states.
//  Direction: on BALL_VALID, approaching <= (BALL_H > last_h) when BALL_H != last_h;
//   held when equal; last_h <= BALL_H. Registered, so it is used from the next cycle.
//  Target (unsigned, COORD_W):
//   - CHASE: BALL_V - PADDLE_H/2, saturating at 0 and at FIELD_H-PADDLE_H.
//   - HOME: HOME_Y.
//   - IDLE: none.
//  FSM, evaluated every cycle, priority top-down:
//   - ENABLE=0 -> IDLE.
//   - approaching && last_h > NET_X -> CHASE.
//   - otherwise -> HOME.
//   IDLE freezes paddle. HOME and CHASE move the paddle only on tick.
//  Move, on tick in HOME/CHASE:
//   - MODE=0: paddle <= target.
//   - MODE=1: d = |target-paddle|. d <= DEADBAND: hold. Else step min(d, MAX_STEP)
//     toward target; never overshoots.
//  MOVING <= (paddle changes on this tick); updated only on tick; cleared in IDLE.
//  paddle never exceeds FIELD_H-PADDLE_H; all subtraction done before compare
//   with explicit borrow checks, no wrap-around.
//  Simultaneous events:
//   - BALL_VALID with tick: the move uses the state/target registered before this
//     edge (one-cycle latency from strobe to FSM).
//   - ENABLE falling with tick: IDLE wins, no move.
//  Latency: BALL_VALID -> STATE update 2 cycles; -> POSITION change at first tick after.
//  Mid-operation reset: all registers return to reset values immediately, regardless of tick.
// TESTING
//  1 Reset: RESET=0 mid-chase -> POSITION=(205>>1)=102, STATE=0, MOVING=0 immediately.
//  2 Snap: TICK_DIV=1, MODE=0, ENABLE=1, BALL_VALID H=400 then H=410, V=300
//    -> STATE=2, POSITION=135 by next tick.
//  3 Rate limit: TICK_DIV=4, MODE=1, paddle 205, chase V=330 (target 300)
//    -> +4 px per tick, MOVING=1, stops at exactly 300 with no overshoot.
//  4 Dead-band/clamp:
//    - target within 2 px -> no move, MOVING=0.
//    - V=5 -> target 0.
//    - V=469 -> target 410.
//  5 Recede/home: chase to 300, then H decreasing 410->400 -> STATE=1,
//    paddle steps back to 205.
//  6 Boundaries: ENABLE=0 coincident with tick -> no move, STATE=0; BALL_H=NET_X
//    approaching -> HOME, not CHASE.

Source files
------------

// File: rtl/ai_paddle_tracker.sv
// rtl/ai_paddle_tracker.sv - computer-player paddle controller: direction detect, rate-limited chase, return-to-home
module ai_paddle_tracker #(
   parameter int COORD_W   = 11,
   parameter int POS_W     = 8,
   parameter int POS_SHIFT = 1,
   parameter int FIELD_H   = 470,
   parameter int PADDLE_H  = 60,
   parameter int NET_X     = 391,
   parameter int TICK_DIV  = 500000,
   parameter int MAX_STEP  = 4,
   parameter int DEADBAND  = 2
) (
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic               ENABLE,
   input  logic               MODE,
   input  logic               BALL_VALID,
   input  logic [COORD_W-1:0] BALL_H,
   input  logic [COORD_W-1:0] BALL_V,
   output logic [POS_W-1:0]   POSITION,
   output logic               MOVING,
   output logic [1:0]         STATE
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOME  = 2'd1,
      ST_CHASE = 2'd2
   } state_e;

   localparam int                 MAX_Y_I = FIELD_H - PADDLE_H;
   localparam logic [COORD_W-1:0] MAX_Y   = COORD_W'(MAX_Y_I);
   localparam logic [COORD_W-1:0] HOME_Y  = COORD_W'(MAX_Y_I / 2);
   localparam logic [COORD_W-1:0] HALF_H  = COORD_W'(PADDLE_H / 2);
   localparam logic [COORD_W-1:0] NET_XC  = COORD_W'(NET_X);
   localparam logic [COORD_W-1:0] DB      = COORD_W'(DEADBAND);
   localparam logic [COORD_W-1:0] STEP    = COORD_W'(MAX_STEP);
   localparam int                 CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [COORD_W-1:0] last_h_q, last_h_d;
   logic [COORD_W-1:0] last_v_q, last_v_d;
   logic               approaching_q, approaching_d;
   logic [COORD_W-1:0] paddle_q, paddle_d;
   logic               moving_q, moving_d;

   logic               tick;
   logic [COORD_W-1:0] target;
   logic [COORD_W-1:0] diff;
   logic [COORD_W-1:0] step_amt;
   logic [COORD_W-1:0] paddle_new;
   logic               up;
   logic [COORD_W-1:0] pos_full;

   always_comb begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   // Equal successive H samples carry no direction information, so hold.
   always_comb begin
      last_h_d      = last_h_q;
      last_v_d      = last_v_q;
      approaching_d = approaching_q;
      if (BALL_VALID) begin
         last_h_d = BALL_H;
         last_v_d = BALL_V;
         if (BALL_H != last_h_q) approaching_d = (BALL_H > last_h_q);
      end
   end

   always_comb begin
      state_d = ST_HOME;
      if (!ENABLE)                                 state_d = ST_IDLE;
      else if (approaching_q && last_h_q > NET_XC) state_d = ST_CHASE;
   end

   always_comb begin
      target = HOME_Y;
      if (state_q == ST_CHASE) begin
         if (last_v_q < HALF_H)                 target = '0;
         else if ((last_v_q - HALF_H) > MAX_Y)  target = MAX_Y;
         else                                   target = last_v_q - HALF_H;
      end
   end

   always_comb begin
      up         = (target >= paddle_q);
      diff       = up ? (target - paddle_q) : (paddle_q - target);
      step_amt   = (diff > STEP) ? STEP : diff;
      paddle_new = paddle_q;
      if (!MODE)          paddle_new = target;
      else if (diff > DB) paddle_new = up ? (paddle_q + step_amt) : (paddle_q - step_amt);

      paddle_d = paddle_q;
      moving_d = moving_q;
      // A falling ENABLE blocks the move even while state_q still says HOME/CHASE.
      if (!ENABLE || state_q == ST_IDLE) begin
         moving_d = 1'b0;
      end else if (tick) begin
         paddle_d = paddle_new;
         moving_d = (paddle_new != paddle_q);
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         last_h_q      <= '0;
         last_v_q      <= '0;
         approaching_q <= 1'b0;
         paddle_q      <= HOME_Y;
         moving_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_h_q      <= last_h_d;
         last_v_q      <= last_v_d;
         approaching_q <= approaching_d;
         paddle_q      <= paddle_d;
         moving_q      <= moving_d;
      end
   end

   always_comb begin
      pos_full = paddle_q >> POS_SHIFT;
      POSITION = pos_full[POS_W-1:0];
      MOVING   = moving_q;
      STATE    = state_q;
   end

endmodule

// File: tb/tb_ai_paddle_tracker.sv
// tb/tb_ai_paddle_tracker.sv - directed self-checking bench for ai_paddle_tracker
module tb_ai_paddle_tracker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        mode;
   logic        ball_valid;
   logic [10:0] ball_h;
   logic [10:0] ball_v;
   logic [7:0]  pos_a, pos_b;
   logic        mov_a, mov_b;
   logic [1:0]  st_a, st_b;
   int          passed = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   ai_paddle_tracker #(.TICK_DIV(1)) dut_a (
      .CLOCK(clk), .RESET(rst_n), .ENABLE(enable), .MODE(mode),
      .BALL_VALID(ball_valid), .BALL_H(ball_h), .BALL_V(ball_v),
      .POSITION(pos_a), .MOVING(mov_a), .STATE(st_a)
   );

   ai_paddle_tracker #(.TICK_DIV(4)) dut_b (
      .CLOCK(clk), .RESET(rst_n), .ENABLE(enable), .MODE(mode),
      .BALL_VALID(ball_valid), .BALL_H(ball_h), .BALL_V(ball_v),
      .POSITION(pos_b), .MOVING(mov_b), .STATE(st_b)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input int h, input int v);
      ball_h     = 11'(h);
      ball_v     = 11'(v);
      ball_valid = 1'b1;
      step(1);
      ball_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; enable = 1'b0; mode = 1'b0; ball_valid = 1'b0; ball_h = '0; ball_v = '0;
      step(2);
      total++; if (pos_b !== 8'd102) $display("FAIL reset_pos got %0d want 102", pos_b); else passed++;
      total++; if (st_b !== 2'd0) $display("FAIL reset_state got %0d want 0", st_b); else passed++;
      total++; if (mov_b !== 1'b0) $display("FAIL reset_moving got %0d want 0", mov_b); else passed++;
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_snap;
      enable = 1'b1; mode = 1'b0;
      strobe(400, 300);
      strobe(410, 300);
      step(6);
      total++; if (st_a !== 2'd2) $display("FAIL snap_state_a got %0d want 2", st_a); else passed++;
      total++; if (pos_a !== 8'd135) $display("FAIL snap_pos_a got %0d want 135", pos_a); else passed++;
      total++; if (pos_b !== 8'd135) $display("FAIL snap_pos_b got %0d want 135", pos_b); else passed++;
   endtask

   task automatic test_reset_midchase;
      rst_n = 1'b0;
      #1;
      total++; if (pos_a !== 8'd102) $display("FAIL midreset_pos got %0d want 102", pos_a); else passed++;
      total++; if (st_a !== 2'd0) $display("FAIL midreset_state got %0d want 0", st_a); else passed++;
      total++; if (mov_a !== 1'b0) $display("FAIL midreset_moving got %0d want 0", mov_a); else passed++;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_rate;
      int prev, changes, cyc, bad;
      mode = 1'b1; enable = 1'b1;
      strobe(400, 330);
      strobe(410, 330);
      prev = 102; changes = 0; bad = 0; cyc = 0;
      while (pos_b != 8'd150 && cyc < 400) begin
         step(1);
         cyc++;
         if (int'(pos_b) != prev) begin
            changes++;
            if (int'(pos_b) != prev + 2 || mov_b !== 1'b1) bad++;
            prev = int'(pos_b);
         end
      end
      total++; if (pos_b !== 8'd150) $display("FAIL rate_reach got %0d want 150 after %0d cycles", pos_b, cyc); else passed++;
      total++; if (bad != 0) $display("FAIL rate_step bad_steps %0d want 0", bad); else passed++;
      total++; if (changes != 24) $display("FAIL rate_count got %0d want 24", changes); else passed++;
      step(10);
      total++; if (pos_b !== 8'd150) $display("FAIL rate_overshoot got %0d want 150", pos_b); else passed++;
      total++; if (mov_b !== 1'b0) $display("FAIL rate_stop_moving got %0d want 0", mov_b); else passed++;
      total++; if (st_b !== 2'd2) $display("FAIL rate_state got %0d want 2", st_b); else passed++;
   endtask

   task automatic test_deadband_clamp;
      strobe(420, 331);
      step(10);
      total++; if (pos_b !== 8'd150) $display("FAIL db1_pos got %0d want 150", pos_b); else passed++;
      total++; if (mov_b !== 1'b0) $display("FAIL db1_moving got %0d want 0", mov_b); else passed++;
      strobe(425, 332);
      step(10);
      total++; if (pos_b !== 8'd150) $display("FAIL db2_pos got %0d want 150", pos_b); else passed++;
      mode = 1'b0;
      strobe(430, 5);
      step(8);
      total++; if (pos_b !== 8'd0) $display("FAIL clamp_low got %0d want 0", pos_b); else passed++;
      strobe(440, 469);
      step(8);
      total++; if (pos_b !== 8'd205) $display("FAIL clamp_high got %0d want 205", pos_b); else passed++;
      total++; if (st_b !== 2'd2) $display("FAIL clamp_state got %0d want 2", st_b); else passed++;
   endtask

   task automatic test_home;
      int prev, changes, cyc, bad;
      strobe(450, 330);
      step(8);
      total++; if (pos_b !== 8'd150) $display("FAIL home_setup got %0d want 150", pos_b); else passed++;
      mode = 1'b1;
      strobe(410, 330);
      step(1);
      total++; if (st_b !== 2'd1) $display("FAIL home_state got %0d want 1", st_b); else passed++;
      prev = int'(pos_b); changes = 0; bad = 0; cyc = 0;
      if (prev != 150) changes = 1;
      while (pos_b != 8'd102 && cyc < 400) begin
         step(1);
         cyc++;
         if (int'(pos_b) != prev) begin
            changes++;
            if (int'(pos_b) != prev - 2) bad++;
            prev = int'(pos_b);
         end
      end
      total++; if (pos_b !== 8'd102) $display("FAIL home_reach got %0d want 102 after %0d cycles", pos_b, cyc); else passed++;
      total++; if (bad != 0) $display("FAIL home_step bad_steps %0d want 0", bad); else passed++;
      total++; if (changes != 24) $display("FAIL home_count got %0d want 24", changes); else passed++;
      step(10);
      total++; if (pos_b !== 8'd102) $display("FAIL home_hold got %0d want 102", pos_b); else passed++;
      total++; if (mov_b !== 1'b0) $display("FAIL home_moving got %0d want 0", mov_b); else passed++;
   endtask

   task automatic test_boundaries;
      mode = 1'b0;
      strobe(420, 400);
      step(1);
      total++; if (st_a !== 2'd2) $display("FAIL bnd_chase got %0d want 2", st_a); else passed++;
      total++; if (pos_a !== 8'd102) $display("FAIL bnd_premove got %0d want 102", pos_a); else passed++;
      enable = 1'b0;
      step(1);
      total++; if (pos_a !== 8'd102) $display("FAIL bnd_en_tick_pos got %0d want 102", pos_a); else passed++;
      total++; if (st_a !== 2'd0) $display("FAIL bnd_en_tick_state got %0d want 0", st_a); else passed++;
      total++; if (mov_a !== 1'b0) $display("FAIL bnd_en_tick_moving got %0d want 0", mov_a); else passed++;
      step(5);
      total++; if (pos_a !== 8'd102) $display("FAIL bnd_idle_freeze got %0d want 102", pos_a); else passed++;
      enable = 1'b1;
      strobe(100, 200);
      strobe(391, 200);
      step(1);
      total++; if (st_a !== 2'd1) $display("FAIL bnd_netx_a got %0d want 1", st_a); else passed++;
      total++; if (st_b !== 2'd1) $display("FAIL bnd_netx_b got %0d want 1", st_b); else passed++;
      strobe(392, 200);
      step(1);
      total++; if (st_a !== 2'd2) $display("FAIL bnd_netx_plus1 got %0d want 2", st_a); else passed++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_snap();
      test_reset_midchase();
      test_rate();
      test_deadband_clamp();
      test_home();
      test_boundaries();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
